multicycle_cpu: RTL and testbench
=================================

# multicycle_cpu

Multicycle MIPS-subset core that replaces the single-cycle datapath with an FSM-sequenced datapath. All instruction fetches and data accesses go through one shared memory port with a req/ready handshake, so it tolerates variable-latency memory. Reset vector is parametrised, and the branch delay slot is preserved. It sits between the top level and the shared memory/bus bridge.

## Interface
- RESET_PC, 32'hbfc0_0000, address of the first fetch after reset
- DATA_W, 32, datapath/register width; addresses are always 32 bits
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write (sw), 0 = read (fetch/lw)
- mem_addr  out  32  byte address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  transaction completes on a clock edge where mem_req & mem_ready
- mem_rdata  in  DATA_W  read data, valid in the completing cycle
- pc  out  32  address of the instruction currently executing
- retire  out  1  one-cycle pulse in the last cycle of each instruction
- perf_cycles  out  32  cycle counter (see Configuration)
- perf_retired  out  32  retired-instruction counter (see Configuration)

## Operation
- ISA: addu, subu, and, or, xor, slt, sll, srl, sra, addiu, andi, ori, lui, slti, lw, sw, beq, bne, j, jal, jr. Any other encoding executes as a NOP: it retires and PC advances.
- Internal 32×DATA_W register file; r0 reads 0 and writes to it are dropped; written only in WB.
- PC pair {pc, npc}. Each retire: pc←npc and npc←npc+4, unless a branch/jump is taken, in which case npc←target. This gives exactly one delay slot.
- Branch target = pc+4+(sext(imm)<<2). j/jal target = {(pc+4)[31:28], instr_index, 2'b00}. jr target = rs. jal writes r31 ← pc+8.
- FSM states:
  - FETCH: mem_req=1, we=0, addr=pc. On ready, latch instr → DECODE.
  - DECODE: read rs/rt, resolve branch/jump. beq/bne/j/jr → FETCH (retire). jal → WB. Else → EXEC.
  - EXEC: ALU op, latch aluout. lw/sw → MEM. Else → WB.
  - MEM: mem_req=1, addr=aluout, we=is_sw, wdata=rt. On ready: lw latches rdata → WB; sw → FETCH (retire).
  - WB: write rd/rt/r31 → FETCH (retire).
- While req is pending, addr/we/wdata stay stable until accepted. mem_req is low in every state other than FETCH/MEM.
- Shift amount = instr[10:6]; zero-extend for andi/ori, sign-extend otherwise; arithmetic wraps mod 2^DATA_W, no overflow trap.
- Addresses are not alignment-checked. mem_addr is driven as computed.

## Timing
- Reset (async assert): state=FETCH, pc=RESET_PC, npc=RESET_PC+4, registers=0. mem_req=0, retire=0, mem_we=0, counters=0.
- First mem_req is in the first cycle after resetn deasserts.
- Reset asserted mid-transaction drops mem_req immediately, with no completion. Memory must discard the request.
- Minimum cycles with zero-wait memory (ready=1 on the first req cycle):
  - branch/j/jr: 2
  - jal: 3
  - sw: 4
  - ALU ops: 4
  - lw: 5
- Each wait cycle (req & ~ready) adds exactly 1 cycle.
- retire is high in the final state cycle. pc changes on the following edge.
- Register write in WB is visible to the next instruction's DECODE (no hazards exist).

## Configuration
- MULTICYCLE_CPU_PERF_EN defined: perf_cycles increments every cycle out of reset, and perf_retired increments on each retire. Both wrap at 2^32 and clear on reset.
- MULTICYCLE_CPU_PERF_EN undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Reset release, ready tied 1, mem[0xbfc00000]=addiu r1,r0,5 → first req addr 0xbfc00000; r1=5 after 4 cycles; retire pulses once.
- beq r0,r0,+2 at A, slot addiu r2,r0,1 → slot executes (r2=1), next fetch at A+12.
- jal at 0xbfc00010 → r31=0xbfc00018; delay slot is fetched before the target.
- lw with ready low for 3 cycles → mem_addr/mem_we stable during the wait; load takes 8 cycles; rd=mem_rdata.
- sw r3(0xdeadbeef) to 0x100 → one cycle with req=1, we=1, addr=0x100, wdata=0xdeadbeef; no register write.
- resetn pulsed low during MEM wait → mem_req drops asynchronously; next fetch is at RESET_PC; perf counters=0 (PERF_EN build).

Source files
------------

// File: rtl/multicycle_cpu_if.sv
// Shared instruction/data memory port of multicycle_cpu. A transfer completes on the
// clock edge where mem_req and mem_ready are both high.
interface multicycle_cpu_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core, 2..5 cycles per instruction (+1 per memory wait cycle); stalls while mem_req & ~mem_ready.
// Perf counters are built only when MULTICYCLE_CPU_PERF_EN is defined, otherwise tied to 0.
module multicycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DATA_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  multicycle_cpu_if.master mem,
  output logic [31:0]      pc,
  output logic             retire,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_retired
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                         OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_LW   = 6'h23, OP_SW  = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08, F_ADDU = 6'h21,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2a;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

  state_e            state_q;
  logic [31:0]       pc_q, npc_q, instr_q;
  logic [DATA_W-1:0] aluout_q, mdr_q;
  logic [DATA_W-1:0] rf_q [32];

  logic [5:0]        opc, fn;
  logic [4:0]        rs, rt, rd, sh, wr_addr;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_val, rt_val, sext_imm, zext_imm, alu_d, wb_d;
  logic [31:0]       pc4, npc_d;
  logic              is_rtype, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_ctl;
  logic              r_alu, i_alu, wr_en, taken;

  assign opc      = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign sh       = instr_q[10:6];
  assign fn       = instr_q[5:0];
  assign imm      = instr_q[15:0];
  // r0 is never written, so it reads back its reset value of zero.
  assign rs_val   = rf_q[rs];
  assign rt_val   = rf_q[rt];
  assign sext_imm = {{(DATA_W-16){imm[15]}}, imm};
  assign zext_imm = {{(DATA_W-16){1'b0}}, imm};

  assign is_rtype = (opc == OP_RTYPE);
  assign is_jr    = is_rtype && (fn == F_JR);
  assign is_j     = (opc == OP_J);
  assign is_jal   = (opc == OP_JAL);
  assign is_beq   = (opc == OP_BEQ);
  assign is_bne   = (opc == OP_BNE);
  assign is_lw    = (opc == OP_LW);
  assign is_sw    = (opc == OP_SW);
  assign is_ctl   = is_beq || is_bne || is_j || is_jr;

  always_comb begin
    alu_d = '0;
    r_alu = 1'b0;
    i_alu = 1'b0;
    if (is_rtype) begin
      r_alu = 1'b1;
      case (fn)
        F_ADDU:  alu_d = rs_val + rt_val;
        F_SUBU:  alu_d = rs_val - rt_val;
        F_AND:   alu_d = rs_val & rt_val;
        F_OR:    alu_d = rs_val | rt_val;
        F_XOR:   alu_d = rs_val ^ rt_val;
        F_SLT:   alu_d = {{(DATA_W-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
        F_SLL:   alu_d = rt_val << sh;
        F_SRL:   alu_d = rt_val >> sh;
        F_SRA:   alu_d = $signed(rt_val) >>> sh;
        default: r_alu = 1'b0;
      endcase
    end else begin
      i_alu = 1'b1;
      case (opc)
        OP_ADDIU:     alu_d = rs_val + sext_imm;
        OP_ANDI:      alu_d = rs_val & zext_imm;
        OP_ORI:       alu_d = rs_val | zext_imm;
        OP_LUI:       alu_d = sext_imm << 16;
        OP_SLTI:      alu_d = {{(DATA_W-1){1'b0}}, $signed(rs_val) < $signed(sext_imm)};
        OP_LW, OP_SW: begin
          alu_d = rs_val + sext_imm;
          i_alu = 1'b0;
        end
        default:      i_alu = 1'b0;
      endcase
    end
  end

  assign wr_en   = r_alu || i_alu || is_lw || is_jal;
  assign wr_addr = is_jal ? 5'd31 : (is_rtype ? rd : rt);
  assign wb_d    = is_lw ? mdr_q : (is_jal ? DATA_W'(pc_q + 32'd8) : aluout_q);

  assign pc4   = pc_q + 32'd4;
  assign taken = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)) ||
                 is_j || is_jal || is_jr;

  // Only npc is redirected; the instruction at pc+4 still runs as the delay slot.
  always_comb begin
    npc_d = npc_q + 32'd4;
    if (taken) begin
      if (is_jr)              npc_d = rs_val[31:0];
      else if (is_j || is_jal) npc_d = {pc4[31:28], instr_q[25:0], 2'b00};
      else                    npc_d = pc4 + {{14{imm[15]}}, imm, 2'b00};
    end
  end

  // Gated by resetn so an in-flight request vanishes the moment reset asserts.
  assign mem.mem_req   = resetn && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem.mem_we    = (state_q == S_MEM) && is_sw;
  assign mem.mem_addr  = (state_q == S_MEM) ? aluout_q[31:0] : pc_q;
  assign mem.mem_wdata = rt_val;

  assign retire = ((state_q == S_DECODE) && is_ctl) ||
                  ((state_q == S_MEM) && is_sw && mem.mem_ready) ||
                  (state_q == S_WB);
  assign pc     = pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC + 32'd4;
      instr_q  <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (retire) begin
        pc_q  <= npc_q;
        npc_q <= npc_d;
      end
      case (state_q)
        S_FETCH: if (mem.mem_ready) begin
          instr_q <= mem.mem_rdata[31:0];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_ctl)      state_q <= S_FETCH;
          else if (is_jal) state_q <= S_WB;
          else             state_q <= S_EXEC;
        end
        S_EXEC: begin
          aluout_q <= alu_d;
          state_q  <= (is_lw || is_sw) ? S_MEM : S_WB;
        end
        S_MEM: if (mem.mem_ready) begin
          mdr_q   <= mem.mem_rdata;
          state_q <= is_sw ? S_FETCH : S_WB;
        end
        S_WB: begin
          if (wr_en && (wr_addr != 5'd0)) rf_q[wr_addr] <= wb_d;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CPU_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retire) ret_q <= ret_q + 32'd1;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_retired = ret_q;
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed program run for multicycle_cpu: retire trace, per-instruction cycle counts,
// register results, stalled load, store beat and reset during a pending load.
module tb_multicycle_cpu;
  localparam logic [31:0] B = 32'hbfc0_0000;

  logic        clk;
  logic        resetn;
  logic [31:0] pc, perf_cycles, perf_retired;
  logic        retire;
  logic [31:0] imem [256];
  int          stall_left;
  int          n_chk = 0;
  int          n_fail = 0;

  multicycle_cpu_if #(.DATA_W(32)) m ();

  multicycle_cpu #(.RESET_PC(B), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem          (m),
    .pc           (pc),
    .retire       (retire),
    .perf_cycles  (perf_cycles),
    .perf_retired (perf_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word array aliased on addr[9:2]; reads of 0x100 stall while stall_left > 0.
  always_comb begin
    m.mem_rdata = imem[m.mem_addr[9:2]];
    m.mem_ready = !(m.mem_req && !m.mem_we && (m.mem_addr == 32'h100) && (stall_left > 0));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  logic [31:0] exp_off [25] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h40, 32'h44, 32'h48,
                                32'h4c, 32'h50, 32'h54, 32'h58, 32'h5c, 32'h60, 32'h64, 32'h68,
                                32'h6c, 32'h70, 32'h74, 32'h78, 32'h18, 32'h1c, 32'h80, 32'h84,
                                32'h88};
  int          exp_dur [25] = '{4, 2, 4, 3, 4, 4, 4, 8, 4, 4, 4, 4, 4, 4, 4, 2, 4, 4, 2, 4, 2, 4,
                                4, 2, 4};
  int          reg_idx [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 31};
  logic [31:0] reg_exp [17] = '{32'h0, 32'h5, 32'h1, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeea,
                                32'h1, 32'hfdeadbee, 32'h0deadbee, 32'h28, 32'h0, 32'h5,
                                32'h0000beef, 32'h1, 32'h2d, 32'h5, 32'hbfc00018};

  initial begin
    int  cyc, last_ret, n_ret, n_wr, n_stall;
    bit  stalled, found;

    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]  = enc_i(6'h09, 0, 1, 16'd5);           // addiu r1,r0,5
    imem[1]  = enc_i(6'h04, 0, 0, 16'd2);           // beq r0,r0,+2 -> 0x10
    imem[2]  = enc_i(6'h09, 0, 2, 16'd1);           // slot: addiu r2,r0,1
    imem[3]  = enc_i(6'h09, 0, 2, 16'd7);           // skipped
    imem[4]  = enc_j(6'h03, B + 32'h40);            // jal 0x40
    imem[5]  = enc_i(6'h0f, 0, 3, 16'hdead);        // slot: lui r3
    imem[6]  = enc_j(6'h02, B + 32'h80);            // j 0x80
    imem[7]  = enc_r(1, 2, 15, 0, 6'h25);           // slot: or r15,r1,r2
    imem[16] = enc_i(6'h0d, 3, 3, 16'hbeef);        // ori r3,r3,0xbeef
    imem[17] = enc_i(6'h2b, 0, 3, 16'h0100);        // sw r3,0x100(r0)
    imem[18] = enc_i(6'h23, 0, 4, 16'h0100);        // lw r4,0x100(r0)
    imem[19] = enc_r(4, 1, 5, 0, 6'h23);            // subu r5,r4,r1
    imem[20] = enc_r(5, 1, 6, 0, 6'h2a);            // slt r6,r5,r1
    imem[21] = enc_r(0, 4, 7, 4, 6'h03);            // sra r7,r4,4
    imem[22] = enc_r(0, 4, 8, 4, 6'h02);            // srl r8,r4,4
    imem[23] = enc_r(0, 1, 9, 3, 6'h00);            // sll r9,r1,3
    imem[24] = enc_r(4, 3, 10, 0, 6'h26);           // xor r10,r4,r3
    imem[25] = enc_r(4, 1, 11, 0, 6'h24);           // and r11,r4,r1
    imem[26] = enc_i(6'h05, 1, 1, 16'd4);           // bne r1,r1 (not taken)
    imem[27] = enc_i(6'h0c, 4, 12, 16'hffff);       // andi r12,r4,0xffff
    imem[28] = enc_i(6'h0a, 4, 13, 16'hffff);       // slti r13,r4,-1
    imem[29] = enc_r(31, 0, 0, 0, 6'h08);           // jr r31 -> 0x18
    imem[30] = enc_r(1, 9, 14, 0, 6'h21);           // slot: addu r14,r1,r9
    imem[32] = 32'hfc00_0000;                       // undefined opcode
    imem[33] = enc_j(6'h02, B + 32'h84);            // j self
    imem[34] = enc_i(6'h09, 0, 0, 16'd9);           // slot: addiu r0 (dropped)

    resetn     = 1'b0;
    stall_left = 3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", m.mem_req, 0);
    chk("rst_we", m.mem_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_pc", pc, B);
    chk("rst_perf_cyc", perf_cycles, 0);
    chk("rst_perf_ret", perf_retired, 0);

    @(posedge clk);
    #2 resetn = 1'b1;
    cyc = 0; last_ret = 0; n_ret = 0; n_wr = 0; n_stall = 0;
    while (n_ret < 25 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      stalled = 1'b0;
      if (cyc == 1) begin
        chk("first_req", m.mem_req, 1);
        chk("first_addr", m.mem_addr, B);
        chk("first_we", m.mem_we, 0);
      end
      if (m.mem_req && !m.mem_ready) begin
        stalled = 1'b1;
        n_stall++;
        chk($sformatf("stall%0d_addr", n_stall), m.mem_addr, 32'h100);
        chk($sformatf("stall%0d_we", n_stall), m.mem_we, 0);
      end
      if (m.mem_req && m.mem_we && m.mem_ready) begin
        n_wr++;
        chk("sw_addr", m.mem_addr, 32'h100);
        chk("sw_wdata", m.mem_wdata, 32'hdeadbeef);
        imem[m.mem_addr[9:2]] = m.mem_wdata;
      end
      if (retire) begin
        chk($sformatf("ret%0d_pc", n_ret), pc, B + exp_off[n_ret]);
        chk($sformatf("ret%0d_cycles", n_ret), cyc - last_ret, exp_dur[n_ret]);
`ifdef MULTICYCLE_CPU_PERF_EN
        chk($sformatf("ret%0d_perf_ret", n_ret), perf_retired, n_ret);
        chk($sformatf("ret%0d_perf_cyc", n_ret), perf_cycles, cyc - 1);
`else
        chk($sformatf("ret%0d_perf_off", n_ret), perf_cycles | perf_retired, 0);
`endif
        last_ret = cyc;
        n_ret++;
      end
      @(posedge clk);
      #1;
      if (stalled) stall_left--;
    end
    chk("retire_count", n_ret, 25);
    chk("stall_cycles", n_stall, 3);
    chk("store_beats", n_wr, 1);
    for (int i = 0; i < 17; i++)
      chk($sformatf("r%0d", reg_idx[i]), dut.rf_q[reg_idx[i]], reg_exp[i]);

    // Reset asserted while a load is held off by the memory.
    @(negedge clk);
    resetn     = 1'b0;
    stall_left = 1000;
    @(posedge clk);
    #2 resetn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (m.mem_req && !m.mem_we && (m.mem_addr == 32'h100)) found = 1'b1;
    end
    chk("lw_wait_seen", found, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_req", m.mem_req, 0);
    chk("midrst_we", m.mem_we, 0);
    chk("midrst_retire", retire, 0);
    chk("midrst_pc", pc, B);
    chk("midrst_r1", dut.rf_q[1], 0);
    chk("midrst_perf_cyc", perf_cycles, 0);
    chk("midrst_perf_ret", perf_retired, 0);
    stall_left = 0;
    @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("refetch_req", m.mem_req, 1);
    chk("refetch_addr", m.mem_addr, B);
    chk("refetch_we", m.mem_we, 0);
    cyc = 1;
    while (!retire && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("refetch_cycles", cyc, 4);
    chk("refetch_ret_pc", pc, B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
